ppu_sched: RTL
==============

# ppu_sched

Frame/line scheduler in front of the PPU input port. Arbitrates round-robin between up to four byte-stream requesters and grants one requester per line burst of `BURST` bytes. Counts lines, emits the PPU `sync` pulse at each frame boundary, and latches the PPU `mode` once per frame. It is the only driver of the PPU's `data_i`/`stb_i`/`sync`/`mode` inputs.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, legal range 2..4.
- `BURST`, default 32: bytes per grant, equal to one line. Legal range 2..255.
- `LINES`, default 32: lines per frame. Legal range 2..255.
- `SYNC_LEN`, default 2: `sync` pulse width in cycles. Legal range 1..15.
- `TIMEOUT`, default 255: idle cycles inside a burst before it is aborted. Legal range 1..255.

**Ports**
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: scheduler run enable.
- `mode_i` in 3: requested PPU mode, sampled at frame boundary.
- `req_stb` in NUM_REQ: per-requester byte strobe.
- `req_data` in 8*NUM_REQ: requester r's byte is at bits [8r+7:8r].
- `req_ack` out NUM_REQ: per-requester byte accept.
- `ppu_data` out 8: byte to the PPU `data_i`.
- `ppu_stb` out 1: strobe to the PPU `stb_i`.
- `ppu_ack` in 1: accept from the PPU `ack_i`.
- `sync` out 1: frame sync to the PPU.
- `mode_o` out 3: PPU mode.
- `grant` out NUM_REQ: one-hot current grant, zero when none.
- `line_cnt` out 8: current line within the frame.
- `frame_cnt` out 8: frames completed, wraps 255→0.
- `err` out 1: sticky; set on a burst abort.

## Operation

**States:** IDLE, ARB, XFER, SYNC. Reset state is IDLE.

**Reset values (all registered outputs):** `grant`=0, `line_cnt`=0, `frame_cnt`=0, `sync`=0, `mode_o`=0, `err`=0. Internal `last`=NUM_REQ-1, so the first grant goes to requester 0.

**IDLE**
- `enable`=1 → ARB.

**ARB**
- Search requesters `last`+1, `last`+2, … (mod NUM_REQ). Pick the first with `req_stb`=1.
- On a hit: register `grant`, set `last`=winner, clear the byte counter and idle counter, go to XFER.
- On no hit: stay in ARB.
- `enable` is not checked in ARB.

**XFER**
- Combinational outputs:
  - `ppu_stb` = `req_stb[g]`.
  - `ppu_data` = `req_data[g]`.
  - `req_ack[g]` = `ppu_ack` & `req_stb[g]`.
  - All other `req_ack` bits are 0.
- A byte transfers on any cycle where `ppu_stb`=1 and `ppu_ack`=1.
- Each transfer increments the byte counter and clears the idle counter.
- Any other cycle increments the idle counter.

**End of line** (the BURST-th transfer):
- Clear `grant`.
- If `line_cnt`=LINES-1: `line_cnt`←0, `frame_cnt`+1, go to SYNC.
- Otherwise: `line_cnt`+1, then go to ARB if `enable`=1, else IDLE.

**Abort** (idle counter reaches TIMEOUT):
- Set `err`, clear `grant`.
- The line counts as complete, with the same `line_cnt`/frame handling as end of line.
- Bytes not delivered are not replayed.

**SYNC**
- `sync`=1 for SYNC_LEN cycles.
- `mode_o` is loaded from `mode_i` on SYNC entry.
- On exit: go to ARB if `enable`=1, else IDLE.

**Other rules**
- Deasserting `enable` mid-burst does not stop the burst. It takes effect at the line end.
- No `req_ack` and no `ppu_stb` outside XFER.
- `err` clears only on `rst`.

## Timing

- Arbitration costs 1 cycle: ARB → XFER.
- First possible transfer is the cycle after entering XFER.
- Peak throughput is 1 byte/cycle when `ppu_ack` is held high.
- The PPU's registered ack gives 1 byte per 2 cycles.
- Minimum line time is BURST+1 cycles (ARB plus XFER).
- Frame boundary: the cycle after the last transfer of line LINES-1, `sync` is high and `mode_o` shows the new value in that same cycle.
- `sync` pulses are exactly SYNC_LEN cycles, never merged or stretched.
- `rst` asserted at any time: every output reaches its reset value immediately (asynchronous), and any burst in flight is dropped.
- A requester dropping `req_stb` mid-burst stalls the burst; it is not re-arbitrated. Only the timeout frees the grant.
- Simultaneous requests: round-robin guarantees each active requester a grant within NUM_REQ lines.

## Test plan

- **Single requester:** reset, `enable`=1, req0 streams bytes 0..31, `ppu_ack` held high → `grant`=0001 for 32 transfers. `ppu_data` carries 0..31 in order, `line_cnt` goes 0→1, and a second ARB grants req0 again.
- **Round-robin:** all four `req_stb` high → grants run 0,1,2,3,0 on consecutive lines, each line exactly 32 transfers, and no `req_ack` on non-granted requesters.
- **Frame wrap and mode:** LINES=2, SYNC_LEN=2, `mode_i`=3'b101 → after the 64th transfer `sync` is high for 2 cycles, `mode_o`=101, `line_cnt`=0, `frame_cnt`=1.
- **Stall and abort:** TIMEOUT=8, req1 sends 5 bytes then drops `req_stb` → after 8 idle cycles `err`=1, `grant`=0, `line_cnt` increments, and the next ARB grants req2.
- **Enable drop mid-burst:** `enable`→0 at byte 10 → the burst completes all 32 bytes, then IDLE with `ppu_stb`=0. Re-enabling resumes ARB, starting after the last winner.
- **Async reset mid-XFER:** pulse `rst` at byte 15 → `grant`, `ppu_stb`, `sync`, `line_cnt`, `frame_cnt`, `mode_o`, `err` go to 0 without a clock edge. After release, the first grant is to req0.

Source files
------------

// File: rtl/ppu_sched.sv
// Frame/line scheduler feeding the PPU input port: round-robin line grants,
// line/frame counting, frame sync pulse and once-per-frame mode latch.
module ppu_sched #(
  parameter int NUM_REQ  = 4,
  parameter int BURST    = 32,
  parameter int LINES    = 32,
  parameter int SYNC_LEN = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           mode_i,
  input  logic [NUM_REQ-1:0]   req_stb,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           ppu_data,
  output logic                 ppu_stb,
  input  logic                 ppu_ack,
  output logic                 sync,
  output logic [2:0]           mode_o,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           line_cnt,
  output logic [7:0]           frame_cnt,
  output logic                 err
);

  localparam int         IW         = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [7:0] LINE_LAST  = 8'(LINES - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] SYNC_LAST  = 4'(SYNC_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARB, XFER, SYNC} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      last;
  logic [IW-1:0]      gidx;
  logic [7:0]         byte_cnt;
  logic [7:0]         idle_cnt;
  logic [3:0]         sync_cnt;

  logic               arb_hit;
  logic [IW-1:0]      arb_win;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] arb_onehot;
  logic               xfer_fire;
  logic               abort;
  logic               line_end;
  logic               frame_end;

  // Walk the ring from farthest to nearest so the requester right after
  // the previous winner overrides any later candidate.
  always_comb begin
    arb_hit = 1'b0;
    arb_win = last;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (req_stb[cand]) begin
        arb_hit = 1'b1;
        arb_win = cand;
      end
    end
    arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_win;
  end

  always_comb begin
    ppu_stb  = (state == XFER) && req_stb[gidx];
    ppu_data = req_data[{gidx, 3'b000} +: 8];
    req_ack  = '0;
    if (ppu_stb && ppu_ack) begin
      req_ack[gidx] = 1'b1;
    end
    xfer_fire = ppu_stb && ppu_ack;
    abort     = (state == XFER) && !xfer_fire && (idle_cnt == IDLE_LAST);
    line_end  = (xfer_fire && (byte_cnt == BURST_LAST)) || abort;
    frame_end = line_end && (line_cnt == LINE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = ARB;
      ARB:  if (arb_hit) state_nxt = XFER;
      XFER: begin
        if (frame_end) begin
          state_nxt = SYNC;
        end else if (line_end) begin
          state_nxt = enable ? ARB : IDLE;
        end
      end
      SYNC: if (sync_cnt == 4'd0) state_nxt = enable ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborted line is closed exactly like a completed one; the lost bytes
  // are never replayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      gidx      <= '0;
      last      <= IW'(NUM_REQ - 1);
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      sync_cnt  <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      sync      <= 1'b0;
      mode_o    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (arb_hit) begin
            grant    <= arb_onehot;
            gidx     <= arb_win;
            last     <= arb_win;
            byte_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        XFER: begin
          if (xfer_fire) begin
            byte_cnt <= byte_cnt + 8'd1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
          if (abort) begin
            err <= 1'b1;
          end
          if (line_end) begin
            grant <= '0;
            if (frame_end) begin
              line_cnt  <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              sync      <= 1'b1;
              mode_o    <= mode_i;
              sync_cnt  <= SYNC_LAST;
            end else begin
              line_cnt <= line_cnt + 8'd1;
            end
          end
        end
        SYNC: begin
          if (sync_cnt == 4'd0) begin
            sync <= 1'b0;
          end else begin
            sync_cnt <= sync_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
